// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: controller state encodings
// and request type constants.
// Imported by sram_arbiter_2port; the picker is purely combinational and needs none of it.
package sram_arb_pkg;

  // IDLE arbitrates and drives the SRAM; CAPTURE latches read data one cycle
  // after the read; RESP holds the response until the owner accepts it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

endpackage

// File: rtl/sram_arb_picker.sv
// Two-input grant picker: turns a request-valid vector into a one-hot grant.
// Ports: valid[1:0] in, last_grant in (port granted most recently), grant[1:0] out.
// SRAM_ARB_RR_EN defined: a tie goes to the port that did not win last time.
// Undefined: fixed priority, port 0 wins every tie and last_grant is not used.
module sram_arb_picker (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      // Tie: hand the SRAM to whichever port did not have it last.
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter_2port.sv
// Shares one 1rw synchronous SRAM (1-cycle read latency) between two val/rdy clients.
// Ports: clk, reset (sync, active-low); per client reqN_{val,rdy,type,addr,data,byte_en} and
// respN_{val,rdy,data}; SRAM read port (en/addr/data) and write port (en/byte_en/addr/data).
// One transaction at a time: read = 3 cycles min, write = 2 cycles min; a stalled response
// blocks further arbitration. Optional macro SRAM_ARB_RR_EN selects round-robin tie-breaking.
module sram_arbiter_2port
  import sram_arb_pkg::*;
#(
  parameter  int p_data_nbits  = 32,
  parameter  int p_num_entries = 256,
  localparam int c_addr_nbits  = $clog2(p_num_entries),
  localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic                     req0_type,
  input  logic [c_addr_nbits-1:0]  req0_addr,
  input  logic [p_data_nbits-1:0]  req0_data,
  input  logic [c_data_nbytes-1:0] req0_byte_en,

  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic                     req1_type,
  input  logic [c_addr_nbits-1:0]  req1_addr,
  input  logic [p_data_nbits-1:0]  req1_data,
  input  logic [c_data_nbytes-1:0] req1_byte_en,

  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [p_data_nbits-1:0]  resp0_data,

  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [p_data_nbits-1:0]  resp1_data,

  output logic                     sram_read_en,
  output logic [c_addr_nbits-1:0]  sram_read_addr,
  input  logic [p_data_nbits-1:0]  sram_read_data,
  output logic                     sram_write_en,
  output logic [c_data_nbytes-1:0] sram_write_byte_en,
  output logic [c_addr_nbits-1:0]  sram_write_addr,
  output logic [p_data_nbits-1:0]  sram_write_data
);

  state_t                    state, state_next;
  logic                      owner, owner_next;
  logic                      last_grant, last_grant_next;
  logic [p_data_nbits-1:0]   resp_buf, resp_buf_next;

  logic [1:0]                grant;
  logic                      sel;
  logic                      sel_type;
  logic [c_addr_nbits-1:0]   sel_addr;
  logic [p_data_nbits-1:0]   sel_data;
  logic [c_data_nbytes-1:0]  sel_byte_en;

  sram_arb_picker u_picker (
    .valid      ({req1_val, req0_val}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant is one-hot, so bit 1 alone names the winning port.
  assign sel         = grant[1];
  assign sel_type    = sel ? req1_type    : req0_type;
  assign sel_addr    = sel ? req1_addr    : req0_addr;
  assign sel_data    = sel ? req1_data    : req0_data;
  assign sel_byte_en = sel ? req1_byte_en : req0_byte_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;   // port 0 wins the first tie after reset
      resp_buf   <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_grant <= last_grant_next;
      resp_buf   <= resp_buf_next;
    end
  end

  always_comb begin
    state_next         = state;
    owner_next         = owner;
    last_grant_next    = last_grant;
    resp_buf_next      = resp_buf;
    req0_rdy           = 1'b0;
    req1_rdy           = 1'b0;
    resp0_val          = 1'b0;
    resp1_val          = 1'b0;
    resp0_data         = '0;
    resp1_data         = '0;
    sram_read_en       = 1'b0;
    sram_read_addr     = '0;
    sram_write_en      = 1'b0;
    sram_write_byte_en = '0;
    sram_write_addr    = '0;
    sram_write_data    = '0;

    case (state)
      IDLE: begin
        if (|grant) begin
          req0_rdy        = grant[0];
          req1_rdy        = grant[1];
          owner_next      = sel;
          last_grant_next = sel;
          if (sel_type == TYPE_READ) begin
            sram_read_en   = 1'b1;
            sram_read_addr = sel_addr;
            state_next     = CAPTURE;
          end else begin
            sram_write_en      = 1'b1;
            sram_write_addr    = sel_addr;
            sram_write_data    = sel_data;
            sram_write_byte_en = sel_byte_en;
            // Write acks carry zero data, so clear the buffer now.
            resp_buf_next      = '0;
            state_next         = RESP;
          end
        end
      end

      CAPTURE: begin
        resp_buf_next = sram_read_data;
        state_next    = RESP;
      end

      RESP: begin
        if (owner) begin
          resp1_val  = 1'b1;
          resp1_data = resp_buf;
          if (resp1_rdy) state_next = IDLE;
        end else begin
          resp0_val  = 1'b1;
          resp0_data = resp_buf;
          if (resp0_rdy) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // While reset is held low nothing may be handshaken or written, even
    // though the state register only clears on the next edge.
    if (!reset) begin
      req0_rdy           = 1'b0;
      req1_rdy           = 1'b0;
      resp0_val          = 1'b0;
      resp1_val          = 1'b0;
      resp0_data         = '0;
      resp1_data         = '0;
      sram_read_en       = 1'b0;
      sram_read_addr     = '0;
      sram_write_en      = 1'b0;
      sram_write_byte_en = '0;
      sram_write_addr    = '0;
      sram_write_data    = '0;
    end
  end

endmodule
